// File: rtl/ibex_branch_resolve.sv
// rtl/ibex_branch_resolve.sv - in-order tracking of static branch predictions against EX resolution
// Registers a redirect on mispredict and keeps saturating prediction/mispredict counters.
module ibex_branch_resolve #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pred_valid_i,
    output logic             pred_ready_o,
    input  logic [31:0]      pred_pc_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_target_i,
    input  logic             pred_compressed_i,
    input  logic             resolve_valid_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_target_i,
    input  logic             flush_i,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic             resolve_err_o,
    output logic [CNT_W-1:0] pred_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic [31:0]      mem_pc_q     [DEPTH];
    logic [31:0]      mem_pc_d     [DEPTH];
    logic [31:0]      mem_target_q [DEPTH];
    logic [31:0]      mem_target_d [DEPTH];
    logic             mem_taken_q  [DEPTH];
    logic             mem_taken_d  [DEPTH];
    logic             mem_c_q      [DEPTH];
    logic             mem_c_d      [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             resolve_err_q, resolve_err_d;
    logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d, mispred_cnt_q, mispred_cnt_d;

    logic             full, empty, push, pop, mismatch, mispred;
    logic [PTR_W-1:0] rd_idx, wr_idx;
    logic [31:0]      head_pc, head_target, fallthrough_pc, correct_pc;
    logic             head_taken, head_c;

    assign rd_idx      = rd_ptr_q[PTR_W-1:0];
    assign wr_idx      = wr_ptr_q[PTR_W-1:0];
    assign full        = (rd_idx == wr_idx) && (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
    assign empty       = (rd_ptr_q == wr_ptr_q);
    assign pred_ready_o = !full;
    assign push        = pred_valid_i & pred_ready_o;
    assign pop         = resolve_valid_i & !empty;

    assign head_pc     = mem_pc_q[rd_idx];
    assign head_target = mem_target_q[rd_idx];
    assign head_taken  = mem_taken_q[rd_idx];
    assign head_c      = mem_c_q[rd_idx];

    assign mismatch = (resolve_taken_i != head_taken) ||
                      (resolve_taken_i && head_taken && (resolve_target_i != head_target));
    // Flush outranks detection: the controller is already redirecting elsewhere.
    assign mispred        = pop & mismatch & !flush_i;
    assign fallthrough_pc = head_pc + (head_c ? 32'd2 : 32'd4);
    assign correct_pc     = resolve_taken_i ? resolve_target_i : fallthrough_pc;

    always_comb begin
        mem_pc_d      = mem_pc_q;
        mem_target_d  = mem_target_q;
        mem_taken_d   = mem_taken_q;
        mem_c_d       = mem_c_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mispredict_d  = mispred;
        redirect_pc_d = mispred ? correct_pc : redirect_pc_q;
        resolve_err_d = resolve_valid_i & empty;
        pred_cnt_d    = pred_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (flush_i || mispred) begin
            // Everything still queued is on the wrong path; a concurrent push is dropped too.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_pc_d[wr_idx]     = pred_pc_i;
                mem_target_d[wr_idx] = pred_target_i;
                mem_taken_d[wr_idx]  = pred_taken_i;
                mem_c_d[wr_idx]      = pred_compressed_i;
                wr_ptr_d             = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        if (pop && !(&pred_cnt_q)) begin
            pred_cnt_d = pred_cnt_q + CNT_ONE;
        end
        if (mispred && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]     <= '0;
                mem_target_q[i] <= '0;
                mem_taken_q[i]  <= 1'b0;
                mem_c_q[i]      <= 1'b0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            resolve_err_q <= 1'b0;
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mem_pc_q      <= mem_pc_d;
            mem_target_q  <= mem_target_d;
            mem_taken_q   <= mem_taken_d;
            mem_c_q       <= mem_c_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            resolve_err_q <= resolve_err_d;
            pred_cnt_q    <= pred_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispredict_o  = mispredict_q;
    assign redirect_pc_o = redirect_pc_q;
    assign resolve_err_o = resolve_err_q;
    assign pred_cnt_o    = pred_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
    a_no_back_to_back: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        !(mispredict_q && mispredict_d));
    a_ptr_no_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     (wr_ptr_q - rd_ptr_q) <= DEPTH_V);
endmodule

// File: tb/tb_ibex_branch_resolve.sv
// tb/tb_ibex_branch_resolve.sv - directed vector bench for ibex_branch_resolve
module tb_ibex_branch_resolve;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0, pred_ready;
    logic [31:0] pred_pc = '0, pred_target = '0;
    logic        pred_taken = 1'b0, pred_c = 1'b0;
    logic        resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        flush = 1'b0;
    logic        mispredict, resolve_err;
    logic [31:0] redirect_pc;
    logic [31:0] pred_cnt, mispred_cnt;

    int total = 0;
    int bad = 0;
    int exp_pred = 0;
    int exp_mis = 0;
    logic [31:0] exp_redirect = '0;

    ibex_branch_resolve #(.DEPTH(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pred_valid_i(pred_valid), .pred_ready_o(pred_ready),
        .pred_pc_i(pred_pc), .pred_taken_i(pred_taken),
        .pred_target_i(pred_target), .pred_compressed_i(pred_c),
        .resolve_valid_i(resolve_valid), .resolve_taken_i(resolve_taken),
        .resolve_target_i(resolve_target), .flush_i(flush),
        .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
        .resolve_err_o(resolve_err), .pred_cnt_o(pred_cnt), .mispred_cnt_o(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        c;
        logic        r_taken;
        logic [31:0] r_target;
        logic        exp_mis;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic c);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg; pred_c = c;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tg);
        resolve_valid = 1'b1; resolve_taken = tk; resolve_target = tg;
    endtask

    task automatic idle();
        pred_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pred_cnt"}, pred_cnt, exp_pred);
        chk({tag, "_mis_cnt"}, mispred_cnt, exp_mis);
    endtask

    initial begin
        vecs[0] = '{32'h100, 1'b1, 32'hF0, 1'b0, 1'b1, 32'hF0, 1'b0, 32'h0};
        vecs[1] = '{32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300};
        vecs[2] = '{32'h400, 1'b1, 32'h380, 1'b0, 1'b0, 32'h0, 1'b1, 32'h404};
        vecs[3] = '{32'h400, 1'b1, 32'h380, 1'b1, 1'b0, 32'h0, 1'b1, 32'h402};
        vecs[4] = '{32'h500, 1'b1, 32'h600, 1'b0, 1'b1, 32'h640, 1'b1, 32'h640};
        vecs[5] = '{32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[6] = '{32'hFFFFFFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[7] = '{32'hFFFFFFFE, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0};

        #12;
        chk("rst_ready", {31'b0, pred_ready}, 32'd1);
        chk("rst_mis", {31'b0, mispredict}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_err", {31'b0, resolve_err}, 32'd0);
        chk_cnts("rst");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            push(vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].c);
            step();
            idle();
            resolve(vecs[i].r_taken, vecs[i].r_target);
            step();
            idle();
            exp_pred++;
            if (vecs[i].exp_mis) begin
                exp_mis++;
                exp_redirect = vecs[i].exp_pc;
            end
            chk($sformatf("v%0d_mis", i), {31'b0, mispredict}, {31'b0, vecs[i].exp_mis});
            chk($sformatf("v%0d_redirect", i), redirect_pc, exp_redirect);
            chk_cnts($sformatf("v%0d", i));
            step();
            chk($sformatf("v%0d_mis_drop", i), {31'b0, mispredict}, 32'd0);
            chk($sformatf("v%0d_ready", i), {31'b0, pred_ready}, 32'd1);
        end

        // Fill the queue, then mispredict the oldest while a third push is held off.
        push(32'h1000, 1'b0, 32'h0, 1'b0);
        step();
        push(32'h2000, 1'b0, 32'h0, 1'b0);
        step();
        chk("full_ready", {31'b0, pred_ready}, 32'd0);
        push(32'h3000, 1'b0, 32'h0, 1'b0);
        resolve(1'b1, 32'h1100);
        #1;
        chk("full_ready_held", {31'b0, pred_ready}, 32'd0);
        step();
        idle();
        exp_pred++; exp_mis++; exp_redirect = 32'h1100;
        chk("full_mis", {31'b0, mispredict}, 32'd1);
        chk("full_redirect", redirect_pc, exp_redirect);
        chk("full_ready_after", {31'b0, pred_ready}, 32'd1);
        chk_cnts("full");
        resolve(1'b0, 32'h0);
        step();
        idle();
        chk("full_discard_err", {31'b0, resolve_err}, 32'd1);
        chk("full_discard_mis", {31'b0, mispredict}, 32'd0);
        chk_cnts("full_discard");
        step();
        chk("err_one_shot", {31'b0, resolve_err}, 32'd0);

        // Flush alongside a mismatching resolve and a push.
        push(32'h4000, 1'b0, 32'h0, 1'b0);
        step();
        idle();
        push(32'h6000, 1'b0, 32'h0, 1'b0);
        resolve(1'b1, 32'h5000);
        flush = 1'b1;
        step();
        idle();
        exp_pred++;
        chk("flush_mis", {31'b0, mispredict}, 32'd0);
        chk("flush_redirect_hold", redirect_pc, exp_redirect);
        chk_cnts("flush");
        resolve(1'b0, 32'h0);
        step();
        idle();
        chk("flush_empty_err", {31'b0, resolve_err}, 32'd1);
        chk_cnts("flush_empty");

        // Push and pop in the same cycle; the second record must survive.
        push(32'h8000, 1'b0, 32'h0, 1'b0);
        step();
        push(32'h9000, 1'b0, 32'h0, 1'b1);
        resolve(1'b0, 32'h0);
        step();
        idle();
        exp_pred++;
        chk("pp_mis", {31'b0, mispredict}, 32'd0);
        chk("pp_ready", {31'b0, pred_ready}, 32'd1);
        resolve(1'b1, 32'hA000);
        step();
        idle();
        exp_pred++; exp_mis++; exp_redirect = 32'hA000;
        chk("pp_second_mis", {31'b0, mispredict}, 32'd1);
        chk("pp_second_redirect", redirect_pc, exp_redirect);
        chk("pp_second_err", {31'b0, resolve_err}, 32'd0);
        chk_cnts("pp");
        step();

        // Asynchronous reset while a redirect is pending on the outputs.
        push(32'hB000, 1'b1, 32'hB100, 1'b0);
        step();
        idle();
        resolve(1'b0, 32'h0);
        step();
        idle();
        chk("arst_pre_mis", {31'b0, mispredict}, 32'd1);
        chk("arst_pre_redirect", redirect_pc, 32'hB004);
        #2;
        rst_n = 1'b0;
        #1;
        exp_pred = 0; exp_mis = 0;
        chk("arst_mis", {31'b0, mispredict}, 32'd0);
        chk("arst_redirect", redirect_pc, 32'h0);
        chk("arst_ready", {31'b0, pred_ready}, 32'd1);
        chk_cnts("arst");
        #3;
        rst_n = 1'b1;
        step();
        resolve(1'b0, 32'h0);
        step();
        idle();
        chk("arst_queue_empty_err", {31'b0, resolve_err}, 32'd1);
        chk_cnts("arst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
